cplx_dot_seq: RTL and testbench

CPLX_DOT_SEQ -- requirements
Module: cplx_dot_seq

---
 rtl/cplx_dot_seq.sv | 106 ++++++++++
 tb/tb_cplx_dot_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cplx_dot_seq.sv
// cplx_dot_seq: sequential complex dot product sum(a[k]*b[k]) over Q32.32 operands, one element per cycle.
// Define CPLX_DOT_SAT_EN to saturate term conversion and accumulation instead of wrapping.
module cplx_dot_seq #(
  parameter int vec_len = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    valid,
  input  logic [64*vec_len-1:0]   vec_a_real,
  input  logic [64*vec_len-1:0]   vec_a_imag,
  input  logic [64*vec_len-1:0]   vec_b_real,
  input  logic [64*vec_len-1:0]   vec_b_imag,
  input  logic                    out_read_ack,
  output logic [63:0]             out_real,
  output logic [63:0]             out_imag,
  output logic                    done
);
  localparam int iw = vec_len > 1 ? $clog2(vec_len) : 1;
  typedef enum logic [1:0] {IDLE = 2'd0, LOADED = 2'd1, BUSY = 2'd2, DONE = 2'd3} state_t;
  state_t state, state_nx;
  logic [64*vec_len-1:0] a_re, a_im, b_re, b_im;
  logic [63:0] acc_re, acc_im, nx_re, nx_im;
  logic [iw-1:0] idx;
  logic signed [63:0] ar, ai, br, bi;
  logic last;
`ifdef CPLX_DOT_SAT_EN
  localparam logic [63:0] max_v = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] min_v = 64'h8000_0000_0000_0000;
  // Q32.32 product rescaled by floor shift; clamp when bits above the 64-bit window disagree with the sign
  function automatic logic [63:0] term(input logic signed [63:0] x, input logic signed [63:0] y);
    logic signed [127:0] q;
    q = (128'(x) * 128'(y)) >>> 32;
    return (&q[127:63] || ~|q[127:63]) ? q[63:0] : (q[127] ? min_v : max_v);
  endfunction
  function automatic logic [63:0] add(input logic [63:0] x, input logic [63:0] y, input logic sub);
    logic [64:0] s;
    s = sub ? {x[63], x} - {y[63], y} : {x[63], x} + {y[63], y};
    return s[64] == s[63] ? s[63:0] : (s[64] ? min_v : max_v);
  endfunction
`else
  function automatic logic [63:0] term(input logic signed [63:0] x, input logic signed [63:0] y);
    return 64'((128'(x) * 128'(y)) >>> 32);
  endfunction
  function automatic logic [63:0] add(input logic [63:0] x, input logic [63:0] y, input logic sub);
    return sub ? x - y : x + y;
  endfunction
`endif
  assign ar = a_re[64*idx +: 64];
  assign ai = a_im[64*idx +: 64];
  assign br = b_re[64*idx +: 64];
  assign bi = b_im[64*idx +: 64];
  assign nx_re = add(add(acc_re, term(ar, br), 1'b0), term(ai, bi), 1'b1);
  assign nx_im = add(add(acc_im, term(ar, bi), 1'b0), term(ai, br), 1'b0);
  assign last = idx == iw'(vec_len - 1);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = valid ? LOADED : IDLE;
      LOADED:  state_nx = start ? BUSY : LOADED;
      BUSY:    state_nx = last ? DONE : BUSY;
      default: state_nx = out_read_ack ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_re     <= '0;
      a_im     <= '0;
      b_re     <= '0;
      b_im     <= '0;
      acc_re   <= '0;
      acc_im   <= '0;
      idx      <= '0;
      out_real <= '0;
      out_imag <= '0;
      done     <= 1'b0;
    end else begin
      // start wins over a same-cycle recapture so the held operands are used
      if (valid && (state == IDLE || (state == LOADED && !start))) begin
        a_re <= vec_a_real;
        a_im <= vec_a_imag;
        b_re <= vec_b_real;
        b_im <= vec_b_imag;
      end
      if (state == LOADED && start) begin
        acc_re <= '0;
        acc_im <= '0;
        idx    <= '0;
      end
      if (state == BUSY) begin
        acc_re <= nx_re;
        acc_im <= nx_im;
        idx    <= idx + 1'b1;
        if (last) begin
          out_real <= nx_re;
          out_imag <= nx_im;
          done     <= 1'b1;
        end
      end
      if (state == DONE && out_read_ack)
        done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cplx_dot_seq.sv
// tb_cplx_dot_seq: directed + random scoreboard bench driving a vec_len=2 and a vec_len=4 instance in lockstep.
module tb_cplx_dot_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, valid = 1'b0, ack = 1'b0;
  logic [255:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic [63:0] re2, im2, re4, im4, l2r, l2i, l4r, l4i;
  logic done2, done4;
  logic [63:0] q2[$], q4[$];
  int n = 0, errs = 0;
  localparam logic [63:0] one = 64'h1_0000_0000;

  always #5 clk = ~clk;

  cplx_dot_seq #(.vec_len(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .valid(valid),
    .vec_a_real(a_re[127:0]), .vec_a_imag(a_im[127:0]),
    .vec_b_real(b_re[127:0]), .vec_b_imag(b_im[127:0]),
    .out_read_ack(ack), .out_real(re2), .out_imag(im2), .done(done2));

  cplx_dot_seq #(.vec_len(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .valid(valid),
    .vec_a_real(a_re), .vec_a_imag(a_im), .vec_b_real(b_re), .vec_b_imag(b_im),
    .out_read_ack(ack), .out_real(re4), .out_imag(im4), .done(done4));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
  endtask

  task automatic set_el(input int k, input logic [63:0] ar, ai, br, bi);
    a_re[64*k +: 64] = ar;
    a_im[64*k +: 64] = ai;
    b_re[64*k +: 64] = br;
    b_im[64*k +: 64] = bi;
  endtask

  function automatic logic [63:0] tm(input logic [63:0] x, input logic [63:0] y);
    logic signed [127:0] p;
    p = $signed({{64{x[63]}}, x}) * $signed({{64{y[63]}}, y});
    return p[95:32];
  endfunction

  task automatic model(input int len, output logic [63:0] r, output logic [63:0] i);
    r = '0;
    i = '0;
    for (int k = 0; k < len; k++) begin
      r = r + tm(a_re[64*k +: 64], b_re[64*k +: 64]) - tm(a_im[64*k +: 64], b_im[64*k +: 64]);
      i = i + tm(a_re[64*k +: 64], b_im[64*k +: 64]) + tm(a_im[64*k +: 64], b_re[64*k +: 64]);
    end
  endtask

  function automatic logic [63:0] rnd();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return {{24{v[39]}}, v[39:0]};
  endfunction

  // load, start, then watch both instances for done with a bounded cycle budget
  task automatic run(input logic [63:0] e2r, e2i, e4r, e4i, input int hold);
    bit g2 = 0, g4 = 0;
    q2.push_back(e2r); q2.push_back(e2i);
    q4.push_back(e4r); q4.push_back(e4i);
    valid = 1'b1; tick; valid = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    for (int c = 1; c <= 8 && !(g2 && g4); c++) begin
      tick;
      if (done2 && !g2) begin
        g2 = 1;
        chk("latency2", 64'(c), 64'd2);
        l2r = q2.pop_front(); l2i = q2.pop_front();
        chk("out_real2", re2, l2r);
        chk("out_imag2", im2, l2i);
      end
      if (done4 && !g4) begin
        g4 = 1;
        chk("latency4", 64'(c), 64'd4);
        l4r = q4.pop_front(); l4i = q4.pop_front();
        chk("out_real4", re4, l4r);
        chk("out_imag4", im4, l4i);
      end
    end
    if (!g2) chk("timeout2", {63'b0, done2}, 64'd1);
    if (!g4) chk("timeout4", {63'b0, done4}, 64'd1);
    repeat (hold) begin
      tick;
      chk("hold_done2", {63'b0, done2}, 64'd1);
      chk("hold_done4", {63'b0, done4}, 64'd1);
      chk("hold_re2", re2, l2r);
      chk("hold_im4", im4, l4i);
    end
  endtask

  task automatic ack_cycle;
    ack = 1'b1; tick; ack = 1'b0;
    chk("ack_done2", {63'b0, done2}, 64'd0);
    chk("ack_done4", {63'b0, done4}, 64'd0);
    chk("retain_re2", re2, l2r);
    chk("retain_re4", re4, l4r);
  endtask

  initial begin
    logic [63:0] r2, i2, r4, i4;
    tick; tick;
    chk("rst_done2", {63'b0, done2}, 64'd0);
    chk("rst_done4", {63'b0, done4}, 64'd0);
    chk("rst_re2", re2, 64'd0);
    chk("rst_im4", im4, 64'd0);
    rst = 1'b0;
    // basic vector, held 5 cycles in DONE
    clr;
    set_el(0, one, 2 * one, 4 * one, 0);
    set_el(1, 3 * one, 0, 0, one);
    run(64'h0000_0004_0000_0000, 64'h0000_000B_0000_0000,
        64'h0000_0004_0000_0000, 64'h0000_000B_0000_0000, 5);
    // ack with valid: back to IDLE without capture, so a following start is ignored
    clr;
    set_el(0, 64'hFFFF_FFFE_8000_0000, 0, 2 * one, 0);
    valid = 1'b1; ack = 1'b1; tick; valid = 1'b0;
    chk("ackvalid_done2", {63'b0, done2}, 64'd0);
    chk("ackvalid_done4", {63'b0, done4}, 64'd0);
    start = 1'b1; tick; start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("nocap_done2", {63'b0, done2}, 64'd0);
      chk("nocap_done4", {63'b0, done4}, 64'd0);
    end
    chk("nocap_re2", re2, 64'h0000_0004_0000_0000);
    // sign test with ack held high throughout
    run(64'hFFFF_FFFD_0000_0000, 64'd0, 64'hFFFF_FFFD_0000_0000, 64'd0, 0);
    ack = 1'b0;
    ack_cycle;
    // truncation toward minus infinity: 2^-32 * -2^-32
    clr;
    set_el(0, 64'd1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
    ack_cycle;
    // overflow of the accumulator
    clr;
    set_el(0, 64'h0000_8000_0000_0000, 0, 64'h0000_8000_0000_0000, 0);
    set_el(1, 64'h0000_8000_0000_0000, 0, 64'h0000_8000_0000_0000, 0);
`ifdef CPLX_DOT_SAT_EN
    run(64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 0);
`else
    run(64'h8000_0000_0000_0000, 64'd0, 64'h8000_0000_0000_0000, 64'd0, 0);
`endif
    ack_cycle;
    // reset while the vec_len=4 instance sits at index 1
    for (int k = 0; k < 4; k++) set_el(k, 5 * one, one, 3 * one, 7 * one);
    valid = 1'b1; tick; valid = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    tick;
    rst = 1'b1; tick; rst = 1'b0;
    chk("midrst_done4", {63'b0, done4}, 64'd0);
    chk("midrst_re4", re4, 64'd0);
    chk("midrst_im4", im4, 64'd0);
    chk("midrst_re2", re2, 64'd0);
    start = 1'b1; tick; start = 1'b0;
    tick; tick; tick;
    chk("midrst_idle4", {63'b0, done4}, 64'd0);
    // fresh transaction after the abort, then random vectors
    clr;
    set_el(0, one, 0, 2 * one, 0);
    set_el(2, 3 * one, 0, 0, 3 * one);
    run(64'h0000_0002_0000_0000, 64'd0, 64'h0000_0002_0000_0000, 64'h0000_0009_0000_0000, 0);
    ack_cycle;
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 4; k++) set_el(k, rnd(), rnd(), rnd(), rnd());
      model(2, r2, i2);
      model(4, r4, i4);
      run(r2, i2, r4, i4, 0);
      ack_cycle;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
